idu: RTL and testbench
======================

# idu

Instruction decode unit: the stage directly downstream of the instruction fetch unit. Accepts one 32-bit instruction plus its PC per handshake, decodes the R-type subset (ADD, OR, AND, SLL, SRL, MUL, XOR, HCF), reads two 64-bit operands from an internal 32-entry register file, and presents a registered decode packet to the execute stage. An accepted HCF instruction latches a sticky halt that stops further fetch acceptance.

## Interface
- XLEN, 64, register and operand width
- PC_W, 64, PC width
- CLOCK  in  1  sole clock, all state updates on rising edge
- RESET  in  1  synchronous, active-low reset; sampled on rising CLOCK
- IF_VALID  in  1  fetch offers an instruction
- IF_INSTR  in  32  instruction word
- IF_PC  in  PC_W  PC of IF_INSTR
- IF_READY  out  1  idu can accept this cycle
- WB_EN  in  1  writeback write enable
- WB_RD  in  5  writeback destination
- WB_DATA  in  XLEN  writeback value
- ID_VALID  out  1  decode packet valid
- ID_READY  in  1  execute accepts packet
- ID_PC  out  PC_W  PC of packet
- ID_OP  out  4  ALU op code (package enum)
- ID_RD  out  5  destination register
- ID_RS1_VAL, ID_RS2_VAL  out  XLEN  operand values
- ID_WE  out  1  packet writes ID_RD
- ID_ILLEGAL  out  1  packet is an undecodable instruction
- HALT  out  1  sticky; HCF accepted

## Operation
- Decode: opcode 0110011 required. funct7=0000000: funct3 000 ADD, 110 OR, 111 AND, 001 SLL, 101 SRL, 010 MUL, 100 XOR. funct7=0000001 with funct3=000: HCF. Anything else: illegal.
- ID_OP encoding: ADD=0, OR=1, AND=2, SLL=3, SRL=4, MUL=5, XOR=6, HCF=7, NOP=15.
- ID_WE=1 only for legal non-HCF ops with rd≠0. HCF and illegal: ID_WE=0; illegal also ID_OP=NOP, ID_ILLEGAL=1.
- Register file: 32×XLEN, x0 reads 0, writes to x0 ignored. Write on rising edge when WB_EN.
- Bypass: read of rs with WB_EN=1 and WB_RD==rs≠0 in the same cycle returns WB_DATA.
- Operands captured at accept time; no further tracking of in-flight writers (in-order single issue).
- Illegal instructions flagged only; they do not halt.

## Timing
- Reset (RESET=0 at edge): ID_VALID=0, all ID_* fields 0, HALT=0, all registers cleared to 0. IF_READY=0 while RESET=0.
- IF_READY = RESET & !HALT & (!ID_VALID | ID_READY), combinational.
- Accept when IF_VALID & IF_READY; packet appears registered on the next edge: latency 1 cycle, throughput 1/cycle.
- Output held stable while ID_VALID & !ID_READY; ID_VALID drops after handshake if nothing accepted.
- HCF accept: packet issued normally (ID_OP=7); HALT=1 from the same edge; IF_READY=0 thereafter until reset.
- Packet already in flight at HALT is still delivered under the normal handshake.
- Reset mid-operation discards in-flight packet and clears HALT in the same edge.
- Simultaneous WB write and accept reading same register: bypassed value captured; register updated on same edge.

## Structure
- Shared package idu_pkg: opcode/funct constants, ALU op enum (4 bits), XLEN/PC_W defaults; shared with execute stage.
- One sub-module: regfile (2 read ports with WB bypass, 1 write port, x0 hardwired, sync active-low clear).
- Top: combinational decoder, output pipeline register, halt flag.

## Test plan
- Reset: hold RESET=0 three cycles -> ID_VALID=0, HALT=0, IF_READY=0; release -> IF_READY=1 next cycle.
- Write x1=5, x2=7 via WB; offer 0x002081B3 (ADD x3,x1,x2) at PC 0 -> next cycle ID_VALID=1, ID_OP=0, ID_RD=3, operands 5/7, ID_WE=1.
- Offer 0x0020E233 (OR x4,x1,x2) with WB_EN=1, WB_RD=2, WB_DATA=9 same cycle -> ID_RS2_VAL=9; x2 reads 9 afterward.
- Back-pressure: ID_READY=0 for 4 cycles with IF_VALID=1 -> packet stable, IF_READY=0, no instruction lost or duplicated.
- Offer 0x022081B3 (HCF) at PC 4 -> ID_OP=7, ID_WE=0, HALT=1; following offers refused; RESET=0 clears HALT.
- Offer 0x00000013 and funct7=0100000 ADD -> ID_ILLEGAL=1, ID_OP=15, ID_WE=0, HALT stays 0.

Source files
------------

// File: rtl/idu_pkg.sv
// Shared decode definitions for the decode and execute stages.
// Holds the R-type encodings, the ALU op enum and the decode packet.
package idu_pkg;

  localparam int XLEN = 64;
  localparam int PC_W = 64;

  localparam logic [6:0] OPC_OP = 7'b0110011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_HCF = 7'b0000001;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_MUL = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_OR = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_HCF = 3'b000;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_OR = 4'd1,
    OP_AND = 4'd2,
    OP_SLL = 4'd3,
    OP_SRL = 4'd4,
    OP_MUL = 4'd5,
    OP_XOR = 4'd6,
    OP_HCF = 4'd7,
    OP_NOP = 4'd15
  } alu_op_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    alu_op_e op;
    logic [4:0] rd;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic we;
    logic illegal;
  } id_ex_t;

endpackage

// File: rtl/idu_if.sv
// Handshake bundles around the decode stage:
// fetch->decode, writeback->regfile, decode->execute.
interface idu_fetch_if;
  import idu_pkg::*;
  logic IF_VALID;
  logic [31:0] IF_INSTR;
  logic [PC_W-1:0] IF_PC;
  logic IF_READY;

  modport master (
    output IF_VALID, IF_INSTR, IF_PC,
    input IF_READY
  );
  modport slave (
    input IF_VALID, IF_INSTR, IF_PC,
    output IF_READY
  );
endinterface

interface idu_wb_if;
  import idu_pkg::*;
  logic WB_EN;
  logic [4:0] WB_RD;
  logic [XLEN-1:0] WB_DATA;

  modport master (output WB_EN, WB_RD, WB_DATA);
  modport slave (input WB_EN, WB_RD, WB_DATA);
endinterface

interface idu_dec_if;
  import idu_pkg::*;
  logic ID_VALID;
  logic ID_READY;
  logic [PC_W-1:0] ID_PC;
  alu_op_e ID_OP;
  logic [4:0] ID_RD;
  logic [XLEN-1:0] ID_RS1_VAL;
  logic [XLEN-1:0] ID_RS2_VAL;
  logic ID_WE;
  logic ID_ILLEGAL;

  modport master (
    output ID_VALID, ID_PC, ID_OP, ID_RD,
    output ID_RS1_VAL, ID_RS2_VAL,
    output ID_WE, ID_ILLEGAL,
    input ID_READY
  );
  modport slave (
    input ID_VALID, ID_PC, ID_OP, ID_RD,
    input ID_RS1_VAL, ID_RS2_VAL,
    input ID_WE, ID_ILLEGAL,
    output ID_READY
  );
endinterface

// File: rtl/idu_regfile.sv
// 32 x XLEN register file, x0 hardwired to zero.
// Two read ports see a same-cycle writeback through a bypass.
module idu_regfile
  import idu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_val,
  output logic [XLEN-1:0] rs2_val,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  logic [XLEN-1:0] regs [32];

  logic hit1;
  logic hit2;

  assign hit1 = wb_en && (wb_rd == rs1_addr);
  assign hit2 = wb_en && (wb_rd == rs2_addr);

  assign rs1_val = (rs1_addr == 5'd0) ? '0 :
                   hit1 ? wb_data :
                   regs[rs1_addr];

  assign rs2_val = (rs2_addr == 5'd0) ? '0 :
                   hit2 ? wb_data :
                   regs[rs2_addr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_en && (wb_rd != 5'd0)) begin
      regs[wb_rd] <= wb_data;
    end
  end

endmodule

// File: rtl/idu.sv
// Decode stage: R-type decode, operand read, registered packet
// to execute, and a sticky halt raised by an accepted HCF.
module idu
  import idu_pkg::*;
(
  input  logic        CLOCK,
  input  logic        RESET,
  idu_fetch_if.slave  fetch,
  idu_wb_if.slave     wb,
  idu_dec_if.master   dec,
  output logic        HALT
);

  logic [31:0] instr;
  logic [6:0]  opc;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;

  assign instr = fetch.IF_INSTR;
  assign opc = instr[6:0];
  assign rd = instr[11:7];
  assign f3 = instr[14:12];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign f7 = instr[31:25];

  logic is_base;
  logic is_hcf7;

  assign is_base = (opc == OPC_OP) && (f7 == F7_BASE);
  assign is_hcf7 = (opc == OPC_OP) && (f7 == F7_HCF);

  alu_op_e op;
  logic    legal;

  always_comb begin
    op = OP_NOP;
    legal = 1'b1;
    unique case (1'b1)
      is_base && (f3 == F3_ADD): op = OP_ADD;
      is_base && (f3 == F3_OR):  op = OP_OR;
      is_base && (f3 == F3_AND): op = OP_AND;
      is_base && (f3 == F3_SLL): op = OP_SLL;
      is_base && (f3 == F3_SRL): op = OP_SRL;
      is_base && (f3 == F3_MUL): op = OP_MUL;
      is_base && (f3 == F3_XOR): op = OP_XOR;
      is_hcf7 && (f3 == F3_HCF): op = OP_HCF;
      default:                   legal = 1'b0;
    endcase
  end

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  idu_regfile u_rf (
    .clk      (CLOCK),
    .rst_n    (RESET),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_val  (rs1_val),
    .rs2_val  (rs2_val),
    .wb_en    (wb.WB_EN),
    .wb_rd    (wb.WB_RD),
    .wb_data  (wb.WB_DATA)
  );

  id_ex_t pkt_q;
  id_ex_t pkt_d;
  logic   vld_q;
  logic   halt_q;
  logic   accept;

  always_comb begin
    pkt_d = '0;
    pkt_d.pc = fetch.IF_PC;
    pkt_d.op = op;
    pkt_d.rd = rd;
    pkt_d.rs1_val = rs1_val;
    pkt_d.rs2_val = rs2_val;
    pkt_d.we = legal && (op != OP_HCF) && (rd != 5'd0);
    pkt_d.illegal = !legal;
  end

  assign fetch.IF_READY = RESET && !halt_q &&
                          (!vld_q || dec.ID_READY);
  assign accept = fetch.IF_VALID && fetch.IF_READY;

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      pkt_q <= '0;
      vld_q <= 1'b0;
      halt_q <= 1'b0;
    end else if (accept) begin
      pkt_q <= pkt_d;
      vld_q <= 1'b1;
      if (op == OP_HCF) begin
        halt_q <= 1'b1;
      end
    end else if (dec.ID_READY) begin
      vld_q <= 1'b0;
    end
  end

  assign dec.ID_VALID = vld_q;
  assign dec.ID_PC = pkt_q.pc;
  assign dec.ID_OP = pkt_q.op;
  assign dec.ID_RD = pkt_q.rd;
  assign dec.ID_RS1_VAL = pkt_q.rs1_val;
  assign dec.ID_RS2_VAL = pkt_q.rs2_val;
  assign dec.ID_WE = pkt_q.we;
  assign dec.ID_ILLEGAL = pkt_q.illegal;
  assign HALT = halt_q;

endmodule

// File: tb/tb_idu.sv
// Randomized bench for the decode stage: a spec-level model pushes
// expected packets on accept, a monitor pops them on delivery.
module tb_idu;

  logic clk = 1'b0;
  logic RESET = 1'b0;
  logic HALT;

  always #5 clk = ~clk;

  idu_fetch_if f_if ();
  idu_wb_if    w_if ();
  idu_dec_if   d_if ();

  idu dut (
    .CLOCK (clk),
    .RESET (RESET),
    .fetch (f_if),
    .wb    (w_if),
    .dec   (d_if),
    .HALT  (HALT)
  );

  typedef struct {
    logic [63:0] pc;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [63:0] v1;
    logic [63:0] v2;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t        q[$];
  logic [63:0] mregs[32];
  bit          mhalt = 0;
  bit          mon_en = 0;
  logic [63:0] pc = '0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Spec table: funct3 -> op for funct7=0 (3 is unused).
  function automatic logic [3:0] ref_op(logic [31:0] w,
                                        output bit legal);
    logic [3:0] tbl [8];
    tbl = '{4'd0, 4'd3, 4'd5, 4'd15, 4'd6, 4'd4, 4'd1, 4'd2};
    legal = 0;
    if (w[6:0] != 7'h33) return 4'd15;
    if (w[31:25] == 7'd0 && w[14:12] != 3'd3) begin
      legal = 1;
      return tbl[w[14:12]];
    end
    if (w[31:25] == 7'd1 && w[14:12] == 3'd0) begin
      legal = 1;
      return 4'd7;
    end
    return 4'd15;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      chk("id_valid", d_if.ID_VALID, 64'(q.size() != 0));
      if (d_if.ID_VALID && q.size() != 0) begin
        chk("id_pc", d_if.ID_PC, q[0].pc);
        chk("id_op", 64'(d_if.ID_OP), 64'(q[0].op));
        chk("id_we", d_if.ID_WE, q[0].we);
        chk("id_illegal", d_if.ID_ILLEGAL, q[0].ill);
        if (!q[0].ill) begin
          chk("id_rd", d_if.ID_RD, q[0].rd);
          chk("id_rs1", d_if.ID_RS1_VAL, q[0].v1);
          chk("id_rs2", d_if.ID_RS2_VAL, q[0].v2);
        end
        if (d_if.ID_READY) void'(q.pop_front());
      end
    end
  end

  task automatic step(bit v, logic [31:0] ins, bit wen,
                      logic [4:0] wrd, logic [63:0] wdat,
                      bit rdy);
    bit    exp_rdy;
    bit    legal;
    exp_t  e;
    f_if.IF_VALID = v;
    f_if.IF_INSTR = ins;
    f_if.IF_PC = pc;
    w_if.WB_EN = wen;
    w_if.WB_RD = wrd;
    w_if.WB_DATA = wdat;
    d_if.ID_READY = rdy;
    @(negedge clk);
    #1;
    // Monitor has already popped anything leaving this cycle.
    exp_rdy = !mhalt && q.size() == 0;
    chk("halt", HALT, mhalt);
    chk("if_ready", f_if.IF_READY, exp_rdy);
    if (v && exp_rdy) begin
      e.pc = pc;
      e.op = ref_op(ins, legal);
      e.rd = ins[11:7];
      e.v1 = ins[19:15] == 0 ? 64'd0 :
             (wen && wrd == ins[19:15]) ? wdat :
             mregs[ins[19:15]];
      e.v2 = ins[24:20] == 0 ? 64'd0 :
             (wen && wrd == ins[24:20]) ? wdat :
             mregs[ins[24:20]];
      e.we = legal && e.op != 4'd7 && e.rd != 0;
      e.ill = !legal;
      q.push_back(e);
      pc += 4;
      if (e.op == 4'd7) mhalt = 1;
    end
    if (wen && wrd != 0) mregs[wrd] = wdat;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int n);
    mon_en = 0;
    RESET = 1'b0;
    f_if.IF_VALID = 1'b1;
    w_if.WB_EN = 1'b0;
    d_if.ID_READY = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      chk("rst_if_ready", f_if.IF_READY, 0);
      if (i > 0) begin
        chk("rst_valid", d_if.ID_VALID, 0);
        chk("rst_halt", HALT, 0);
        chk("rst_pc", d_if.ID_PC, 0);
        chk("rst_op", 64'(d_if.ID_OP), 0);
        chk("rst_rs1", d_if.ID_RS1_VAL, 0);
        chk("rst_we", d_if.ID_WE, 0);
      end
      @(posedge clk);
      #1;
    end
    q.delete();
    mhalt = 0;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    RESET = 1'b1;
    mon_en = 1;
  endtask

  function automatic logic [31:0] rand_instr();
    int r;
    logic [2:0] f3;
    r = $urandom_range(0, 99);
    f3 = 3'($urandom_range(0, 7));
    if (r < 75) begin
      if (f3 == 3'd3) f3 = 3'd0;
      return {7'd0, 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), f3,
              5'($urandom_range(0, 7)), 7'h33};
    end
    if (r < 82) begin
      return {7'd1, 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), f3,
              5'($urandom_range(0, 7)), 7'h33};
    end
    return $urandom;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int halted_for;
    f_if.IF_VALID = 1'b0;
    f_if.IF_INSTR = '0;
    f_if.IF_PC = '0;
    w_if.WB_EN = 1'b0;
    w_if.WB_RD = '0;
    w_if.WB_DATA = '0;
    d_if.ID_READY = 1'b0;
    @(posedge clk);
    #1;
    do_reset(3);

    step(0, 0, 1, 5'd1, 64'd5, 1);
    step(0, 0, 1, 5'd2, 64'd7, 1);
    pc = 0;
    step(1, 32'h002081B3, 0, 0, 0, 1);
    step(1, 32'h0020E233, 1, 5'd2, 64'd9, 1);
    step(1, 32'h002102B3, 0, 0, 0, 1);
    step(1, 32'h002081B3, 0, 0, 0, 0);
    repeat (4) step(1, 32'h0020E233, 0, 0, 0, 0);
    step(1, 32'h0020E233, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    pc = 4;
    step(1, 32'h022081B3, 0, 0, 0, 1);
    repeat (3) step(1, 32'h002081B3, 0, 0, 0, 1);
    do_reset(2);

    step(0, 0, 1, 5'd1, 64'd3, 1);
    step(1, 32'h00000013, 0, 0, 0, 1);
    step(1, 32'h402081B3, 0, 0, 0, 1);
    step(1, 32'h002081B3, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    halted_for = 0;
    for (int i = 0; i < 800; i++) begin
      if (mhalt) halted_for++;
      if (halted_for > 4 || $urandom_range(0, 99) == 0) begin
        do_reset(2);
        halted_for = 0;
      end
      step($urandom_range(0, 9) < 7, rand_instr(),
           $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 7)),
           {$urandom, $urandom},
           $urandom_range(0, 9) < 7);
    end
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
